// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial nibble adder.
// Contents: FSM state type for the controller and the width of one adder slice.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

endpackage

// File: rtl/nibble_adder_slice.sv
// Combinational 4-bit adder slice: {cout_o, s_o} = a_i + b_i + cin_i.
// Ports:
//   cin_i  carry in
//   a_i    operand A nibble
//   b_i    operand B nibble
//   s_o    sum nibble
//   cout_o carry out
module nibble_adder_slice (
    input  logic       cin_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] s_o,
    output logic       cout_o
);

    // Widened to 5 bits so the carry falls out of the top bit.
    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// Multi-cycle wide add/subtract built around one shared 4-bit adder slice.
// One nibble is processed per cycle, LSB nibble first, with the carry chained
// through a register.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, cin, sub sampled on accept)
//   out_valid / out_ready result handshake (sum, cout, ovf held while valid)
//   busy                 high while an operation is in flight or awaiting hand-off
module serial_nibble_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    input  logic                      sub,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    localparam int unsigned W    = NIBBLE_W * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;     // holds ~b for subtraction
    logic [W-1:0]         sum_q, sum_d;
    logic                 carry_q, carry_d;
    logic [IdxW-1:0]      idx_q, idx_d;

    logic [NIBBLE_W-1:0]  slice_a, slice_b, slice_s;
    logic                 slice_cout;

    // Select the nibble pair addressed by idx_q.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IdxW'(i)) begin
                slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                slice_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder_slice u_slice (
        .cin_i  (carry_q),
        .a_i    (slice_a),
        .b_i    (slice_b),
        .s_o    (slice_s),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is A + ~B + 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
                    end
                end
                carry_d = slice_cout;
                // Index saturates on the last nibble; it is cleared on the next accept.
                if (idx_q == LastIdx) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    // Operands agree in sign but the result does not.
    assign ovf       = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Self-checking bench for serial_nibble_adder_ctrl (NIBBLES = 4).
// Requests are scored against an arithmetic reference model; a negedge monitor
// pops the expected result on every output handshake.
module tb_serial_nibble_adder_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   rand_ready = 1'b0;

    serial_nibble_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Random consumer backpressure, changed well away from both clock edges.
    always begin
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference model: plain unsigned / signed arithmetic on whole operands.
    function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb);
        exp_t   e;
        longint ua, ub, sa, sbv, ur, sr;
        ua  = longint'(av);
        ub  = longint'(bv);
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        if (sb) begin
            ur     = ua - ub;
            sr     = sa - sbv;
            e.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + longint'(ci);
            sr     = sa + sbv + longint'(ci);
            e.cout = (ur >= (longint'(1) << W));
        end
        e.sum = ur[W-1:0];
        e.ovf = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        e.acc = 0;
        return e;
    endfunction

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic send(logic [W-1:0] av, logic [W-1:0] bv, logic ci, logic sb);
        exp_t e;
        int   budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 200) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        e     = model(av, bv, ci, sb);
        e.acc = cyc;
        last_acc = cyc;
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (q.size() != 0 && budget < 400) begin
            budget++;
            @(negedge clk);
        end
        check("drain_empty", q.size(), 0);
    endtask

    // Monitor: every DONE cycle is checked; results are popped on handshake.
    logic         prev_ov = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout, prev_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_in_done", in_ready, 0);
                check("busy_in_done", busy, 1);
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else if (!prev_ov) begin
                    check("latency", cyc - q[0].acc, NIBBLES);
                end else begin
                    check("hold_sum", sum, prev_sum);
                    check("hold_cout", cout, prev_cout);
                    check("hold_ovf", ovf, prev_ovf);
                end
                if (out_ready && q.size() != 0) begin
                    check("sum", sum, q[0].sum);
                    check("cout", cout, q[0].cout);
                    check("ovf", ovf, q[0].ovf);
                    void'(q.pop_front());
                end
            end
            prev_ov   = out_valid;
            prev_sum  = sum;
            prev_cout = cout;
            prev_ovf  = ovf;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } vec_t;

    vec_t vecs[7];
    int   acc0;

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1};

        // Reset values.
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
        drain();

        // Backpressure: hold DONE for 5 cycles, then release.
        @(posedge clk); #2; out_ready = 1'b0;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        begin
            int budget = 0;
            while (!out_valid && budget < 50) begin
                budget++;
                @(negedge clk);
            end
            check("done_reached", out_valid, 1);
        end
        repeat (5) @(negedge clk);
        check("still_waiting", q.size(), 1);
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_after_handshake", in_ready, 1);
        check("valid_drop", out_valid, 0);

        // Back-to-back requests: minimum issue interval.
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        acc0 = last_acc;
        send(16'hA000, 16'h2001, 1'b0, 1'b1);
        check("issue_interval", last_acc - acc0, NIBBLES + 2);
        drain();

        // in_valid pulsed during RUN must be ignored.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("no_extra_op", busy, 0);

        // Reset in RUN cycle 2 aborts the operation.
        send(16'h9999, 16'h1111, 1'b0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_sum", sum, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        drain();

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        repeat (40) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        drain();
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
